// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for a multi-cycle RV32I datapath.
// Drives every datapath mux select and write strobe; memory latency is MEM_LAT cycles.
`default_nettype none

module multicycle_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] instr_i,
  input  logic       stall_i,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done_o,
  output logic       illegal_o
);

  localparam int            CW   = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    ALU_WB   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    LOAD_WB  = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    TRAP     = 4'd12
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          illegal;
  logic          last;

  assign last = (cnt == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= FETCH;
      cnt     <= '0;
      illegal <= 1'b0;
    end else if (!stall_i) begin
      case (state)
        FETCH: begin
          if (last) begin
            state <= DECODE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DECODE: begin
          cnt <= '0;
          case (instr_i)
            OP_R:              state <= EXEC_R;
            OP_I:              state <= EXEC_I;
            OP_LOAD, OP_STORE: state <= MEM_ADDR;
            OP_BR:             state <= BRANCH;
            OP_JAL:            state <= JAL;
            OP_JALR:           state <= JALR;
            default: begin
              state   <= TRAP;
              illegal <= 1'b1;
            end
          endcase
        end
        EXEC_R, EXEC_I: state <= ALU_WB;
        MEM_ADDR: state <= (instr_i == OP_STORE) ? MEM_WR : MEM_RD;
        MEM_RD: begin
          if (last) begin
            state <= LOAD_WB;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        MEM_WR: begin
          if (last) begin
            state <= FETCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ALU_WB, LOAD_WB, BRANCH, JAL, JALR: begin
          state <= FETCH;
          cnt   <= '0;
        end
        TRAP:    state <= TRAP;
        default: begin
          state <= FETCH;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    MemtoReg     = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    PCSource     = 2'b00;
    instr_done_o = 1'b0;
    illegal_o    = illegal;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = last;
        PCWrite = last;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      EXEC_R: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXEC_I: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
      end
      ALU_WB: begin
        RegWrite     = 1'b1;
        instr_done_o = 1'b1;
      end
      MEM_ADDR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
      end
      MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      LOAD_WB: begin
        RegWrite     = 1'b1;
        MemtoReg     = 2'b01;
        instr_done_o = 1'b1;
      end
      MEM_WR: begin
        IorD         = 1'b1;
        MemWrite     = 1'b1;
        instr_done_o = last;
      end
      BRANCH: begin
        ALUSrcA      = 2'b10;
        ALUOp        = 2'b01;
        PCWriteCond  = 1'b1;
        PCSource     = 2'b01;
        instr_done_o = 1'b1;
      end
      JAL: begin
        PCWrite      = 1'b1;
        PCSource     = 2'b01;
        RegWrite     = 1'b1;
        MemtoReg     = 2'b10;
        instr_done_o = 1'b1;
      end
      JALR: begin
        // rd receives the pre-edge PC (old+4) while the PC loads rs1+imm
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b10;
        PCWrite      = 1'b1;
        RegWrite     = 1'b1;
        MemtoReg     = 2'b10;
        instr_done_o = 1'b1;
      end
      default: ;
    endcase

    // A stall freezes the sequence, so no architectural state may change
    if (stall_i) begin
      PCWrite      = 1'b0;
      PCWriteCond  = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      MemWrite     = 1'b0;
      instr_done_o = 1'b0;
    end

    if (rst_i) begin
      PCWrite      = 1'b0;
      PCWriteCond  = 1'b0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      MemtoReg     = 2'b00;
      ALUSrcA      = 2'b00;
      ALUSrcB      = 2'b00;
      ALUOp        = 2'b00;
      PCSource     = 2'b00;
      instr_done_o = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed checks of multicycle_ctrl at MEM_LAT = 1, 2 and 3.
`default_nettype none

module tb_multicycle_ctrl;

  logic       clk;
  logic       rst_v   [1:3];
  logic       stall_v [1:3];
  logic [6:0] instr_v [1:3];
  // {ill, done, PCSource, ALUOp, ALUSrcB, ALUSrcA, MemtoReg, RegWrite, IRWrite, MemWrite, MemRead, IorD, PCWriteCond, PCWrite}
  logic [18:0] o1, o2, o3;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  multicycle_ctrl #(.MEM_LAT(1)) u_l1 (
    .clk_i(clk), .rst_i(rst_v[1]), .instr_i(instr_v[1]), .stall_i(stall_v[1]),
    .PCWrite(o1[0]), .PCWriteCond(o1[1]), .IorD(o1[2]), .MemRead(o1[3]),
    .MemWrite(o1[4]), .IRWrite(o1[5]), .RegWrite(o1[6]), .MemtoReg(o1[8:7]),
    .ALUSrcA(o1[10:9]), .ALUSrcB(o1[12:11]), .ALUOp(o1[14:13]), .PCSource(o1[16:15]),
    .instr_done_o(o1[17]), .illegal_o(o1[18])
  );

  multicycle_ctrl #(.MEM_LAT(2)) u_l2 (
    .clk_i(clk), .rst_i(rst_v[2]), .instr_i(instr_v[2]), .stall_i(stall_v[2]),
    .PCWrite(o2[0]), .PCWriteCond(o2[1]), .IorD(o2[2]), .MemRead(o2[3]),
    .MemWrite(o2[4]), .IRWrite(o2[5]), .RegWrite(o2[6]), .MemtoReg(o2[8:7]),
    .ALUSrcA(o2[10:9]), .ALUSrcB(o2[12:11]), .ALUOp(o2[14:13]), .PCSource(o2[16:15]),
    .instr_done_o(o2[17]), .illegal_o(o2[18])
  );

  multicycle_ctrl #(.MEM_LAT(3)) u_l3 (
    .clk_i(clk), .rst_i(rst_v[3]), .instr_i(instr_v[3]), .stall_i(stall_v[3]),
    .PCWrite(o3[0]), .PCWriteCond(o3[1]), .IorD(o3[2]), .MemRead(o3[3]),
    .MemWrite(o3[4]), .IRWrite(o3[5]), .RegWrite(o3[6]), .MemtoReg(o3[8:7]),
    .ALUSrcA(o3[10:9]), .ALUSrcB(o3[12:11]), .ALUOp(o3[14:13]), .PCSource(o3[16:15]),
    .instr_done_o(o3[17]), .illegal_o(o3[18])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [18:0] v(
      input logic pcw, input logic pcwc, input logic iord, input logic mr,
      input logic mw, input logic irw, input logic rw, input logic [1:0] m2r,
      input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
      input logic [1:0] pcs, input logic done, input logic ill);
    return {ill, done, pcs, op, b, a, m2r, rw, irw, mw, mr, iord, pcwc, pcw};
  endfunction

  function automatic logic [18:0] outs(input int sel);
    if (sel == 1) return o1;
    if (sel == 2) return o2;
    return o3;
  endfunction

  // Expected output vectors per state, built from the control table
  logic [18:0] F, FL, DEC, EXR, EXI, AWB, MAD, MRD, LWB, MWR, MWRL, BR, JL, JR, TR;

  // Leaves the selected DUT at the start of FETCH cycle 1 (posedge + 1)
  task automatic do_reset(input int sel);
    stall_v[sel] = 1'b0;
    rst_v[sel]   = 1'b1;
    @(posedge clk); #1;
    rst_v[sel] = 1'b0;
  endtask

  task automatic test_reset();
    logic [18:0] obs;
    for (int s = 1; s <= 3; s++) begin
      rst_v[s] = 1'b1;
      @(posedge clk); #1;
      obs = outs(s);
      checks++;
      if (obs !== 19'h0) begin
        errors++;
        $display("FAIL reset_outputs L%0d: got %h expected %h", s, obs, 19'h0);
      end
      rst_v[s] = 1'b0;
      #1;
      obs = outs(s);
      checks++;
      if (obs !== ((s == 1) ? FL : F)) begin
        errors++;
        $display("FAIL reset_fetch L%0d: got %h expected %h", s, obs, (s == 1) ? FL : F);
      end
      @(posedge clk); #1;
      rst_v[s] = 1'b1;
    end
  endtask

  task automatic test_alu();
    logic [18:0] exp [9];
    logic [6:0]  ins [9];
    logic [18:0] obs;
    exp = '{FL, DEC, EXR, AWB, FL, DEC, EXI, AWB, FL};
    ins = '{OP_R, OP_R, OP_R, OP_R, OP_I, OP_I, OP_I, OP_I, OP_I};
    do_reset(1);
    for (int i = 0; i < 9; i++) begin
      instr_v[1] = ins[i];
      #1;
      obs = o1;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL alu cyc%0d: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load();
    logic [18:0] exp [10];
    logic [18:0] obs;
    exp = '{F, F, FL, DEC, MAD, MRD, MRD, MRD, LWB, F};
    instr_v[3] = OP_LOAD;
    do_reset(3);
    for (int i = 0; i < 10; i++) begin
      #1;
      obs = o3;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL load_l3 cyc%0d: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] exp [11];
    logic [6:0]  ins [11];
    logic [18:0] obs;
    exp = '{F, FL, DEC, MAD, MWR, MWRL, F, FL, DEC, BR, F};
    ins = '{OP_STORE, OP_STORE, OP_STORE, OP_STORE, OP_STORE, OP_STORE,
            OP_BR, OP_BR, OP_BR, OP_BR, OP_BR};
    do_reset(2);
    for (int i = 0; i < 11; i++) begin
      instr_v[2] = ins[i];
      #1;
      obs = o2;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL store_branch_l2 cyc%0d: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jumps();
    logic [18:0] exp [7];
    logic [6:0]  ins [7];
    logic [18:0] obs;
    exp = '{FL, DEC, JL, FL, DEC, JR, FL};
    ins = '{OP_JAL, OP_JAL, OP_JAL, OP_JALR, OP_JALR, OP_JALR, OP_R};
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      instr_v[1] = ins[i];
      #1;
      obs = o1;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL jal_jalr cyc%0d: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_trap();
    logic [18:0] obs;
    instr_v[1] = OP_SYS;
    do_reset(1);
    for (int i = 0; i < 14; i++) begin
      stall_v[1] = (i >= 6 && i < 9);
      #1;
      obs = o1;
      checks++;
      if (obs !== ((i == 0) ? FL : (i == 1) ? DEC : TR)) begin
        errors++;
        $display("FAIL trap cyc%0d: got %h expected %h", i, obs,
                 (i == 0) ? FL : (i == 1) ? DEC : TR);
      end
      @(posedge clk); #1;
    end
    stall_v[1] = 1'b0;
    rst_v[1]   = 1'b1;
    @(posedge clk); #1;
    obs = o1;
    checks++;
    if (obs !== 19'h0) begin
      errors++;
      $display("FAIL trap_reset: got %h expected %h", obs, 19'h0);
    end
    rst_v[1] = 1'b0;
    #1;
    obs = o1;
    checks++;
    if (obs !== FL) begin
      errors++;
      $display("FAIL trap_refetch: got %h expected %h", obs, FL);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic [18:0] exp [12];
    logic        stl [12];
    logic [18:0] obs;
    // Stall FETCH at count 1 for 4 cycles, then stall the writeback cycle once
    exp = '{F, F, F, F, F, F, FL, DEC, EXR, 19'h0, AWB, F};
    stl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    instr_v[3] = OP_R;
    do_reset(3);
    for (int i = 0; i < 12; i++) begin
      stall_v[3] = stl[i];
      #1;
      obs = o3;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL stall_l3 cyc%0d: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    stall_v[3] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [18:0] obs;
    instr_v[1] = OP_R;
    do_reset(1);
    for (int i = 0; i < 2; i++) begin
      #1;
      obs = o1;
      checks++;
      if (obs !== ((i == 0) ? FL : DEC)) begin
        errors++;
        $display("FAIL midreset_pre cyc%0d: got %h expected %h", i, obs, (i == 0) ? FL : DEC);
      end
      @(posedge clk); #1;
    end
    rst_v[1] = 1'b1;
    #1;
    obs = o1;
    checks++;
    if (obs !== 19'h0) begin
      errors++;
      $display("FAIL midreset_exec: got %h expected %h", obs, 19'h0);
    end
    @(posedge clk); #1;
    rst_v[1] = 1'b0;
    #1;
    obs = o1;
    checks++;
    if (obs !== FL) begin
      errors++;
      $display("FAIL midreset_fetch: got %h expected %h", obs, FL);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int s = 1; s <= 3; s++) begin
      rst_v[s]   = 1'b1;
      stall_v[s] = 1'b0;
      instr_v[s] = 7'b0;
    end
    F    = v(0,0,0,1,0,0,0,2'b00,2'b00,2'b01,2'b00,2'b00,0,0);
    FL   = v(1,0,0,1,0,1,0,2'b00,2'b00,2'b01,2'b00,2'b00,0,0);
    DEC  = v(0,0,0,0,0,0,0,2'b00,2'b01,2'b10,2'b00,2'b00,0,0);
    EXR  = v(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,2'b00,0,0);
    EXI  = v(0,0,0,0,0,0,0,2'b00,2'b10,2'b10,2'b11,2'b00,0,0);
    AWB  = v(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,1,0);
    MAD  = v(0,0,0,0,0,0,0,2'b00,2'b10,2'b10,2'b00,2'b00,0,0);
    MRD  = v(0,0,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,0);
    LWB  = v(0,0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,2'b00,1,0);
    MWR  = v(0,0,1,0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,0);
    MWRL = v(0,0,1,0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,1,0);
    BR   = v(0,1,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b01,1,0);
    JL   = v(1,0,0,0,0,0,1,2'b10,2'b00,2'b00,2'b00,2'b01,1,0);
    JR   = v(1,0,0,0,0,0,1,2'b10,2'b10,2'b10,2'b00,2'b00,1,0);
    TR   = v(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0,1);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_jumps();
    test_trap();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
